// File: rtl/lsu_mem_stage.sv
// Memory stage after execute: drives a valid/ready data-memory bus with byte lanes and emits one writeback beat per instruction.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and pulse misalign with wb_valid.
module lsu_mem_stage #(
  parameter int RD_W = 5,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_load,
  input  logic            ex_store,
  input  logic [2:0]      ex_funct3,
  input  logic [DW-1:0]   ex_addr,
  input  logic [DW-1:0]   ex_wdata,
  input  logic [DW-1:0]   ex_result,
  input  logic [RD_W-1:0] ex_rd,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_we,
  output logic [DW-1:0]   dmem_req_addr,
  output logic [3:0]      dmem_req_be,
  output logic [DW-1:0]   dmem_req_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [DW-1:0]   dmem_rsp_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [RD_W-1:0] wb_rd,
  output logic [DW-1:0]   wb_data
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  logic [1:0]      state_reg, state_next;
  logic            req_we_reg, req_we_next;
  logic [DW-1:0]   req_addr_reg, req_addr_next;
  logic [3:0]      req_be_reg, req_be_next;
  logic [DW-1:0]   req_wdata_reg, req_wdata_next;
  logic [2:0]      f3_reg, f3_next;
  logic [1:0]      lane_reg, lane_next;
  logic [RD_W-1:0] rd_reg, rd_next;
  logic            wb_we_reg, wb_we_next;
  logic [RD_W-1:0] wb_rd_reg, wb_rd_next;
  logic [DW-1:0]   wb_data_reg, wb_data_next;
`ifdef MISALIGN_TRAP_EN
  logic            mis_reg, mis_next;
  logic            mis_calc;
`endif

  // funct3[1:0] selects the access size; encodings 3/6/7 fall through to word
  logic            size_b, size_h, size_w;
  logic [3:0]      be_calc;
  logic [DW-1:0]   st_wdata;

  assign size_b = (ex_funct3[1:0] == 2'b00);
  assign size_h = (ex_funct3[1:0] == 2'b01);
  assign size_w = ~size_b & ~size_h;

  always_comb begin
    be_calc = 4'b1111;
    if (size_b)
      be_calc = 4'b0001 << ex_addr[1:0];
    else if (size_h)
      be_calc = ex_addr[1] ? 4'b1100 : 4'b0011;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_st_lane
      assign st_wdata[8*gi +: 8] = size_b ? ex_wdata[7:0] :
                                   size_h ? ex_wdata[8*(gi%2) +: 8] :
                                            ex_wdata[8*gi +: 8];
    end
  endgenerate

`ifdef MISALIGN_TRAP_EN
  assign mis_calc = (size_h & ex_addr[0]) | (size_w & (ex_addr[1:0] != 2'b00));
`endif

  // Load extraction uses the size/lane captured at accept time
  logic [7:0]    rsp_byte;
  logic [15:0]   rsp_half;
  logic [DW-1:0] load_data;

  assign rsp_byte = dmem_rsp_rdata[{lane_reg, 3'b000} +: 8];
  assign rsp_half = lane_reg[1] ? dmem_rsp_rdata[31:16] : dmem_rsp_rdata[15:0];

  always_comb begin
    load_data = dmem_rsp_rdata;
    case (f3_reg[1:0])
      2'b00:   load_data = {{24{~f3_reg[2] & rsp_byte[7]}}, rsp_byte};
      2'b01:   load_data = {{16{~f3_reg[2] & rsp_half[15]}}, rsp_half};
      default: load_data = dmem_rsp_rdata;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    req_we_next    = req_we_reg;
    req_addr_next  = req_addr_reg;
    req_be_next    = req_be_reg;
    req_wdata_next = req_wdata_reg;
    f3_next        = f3_reg;
    lane_next      = lane_reg;
    rd_next        = rd_reg;
    wb_we_next     = wb_we_reg;
    wb_rd_next     = wb_rd_reg;
    wb_data_next   = wb_data_reg;
`ifdef MISALIGN_TRAP_EN
    mis_next       = mis_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (ex_valid) begin
`ifdef MISALIGN_TRAP_EN
          mis_next = 1'b0;
`endif
          if (ex_load | ex_store) begin
`ifdef MISALIGN_TRAP_EN
            if (mis_calc) begin
              // Trap beat reports the faulting address and writes nothing
              state_next   = ST_WB;
              mis_next     = 1'b1;
              wb_we_next   = 1'b0;
              wb_rd_next   = ex_rd;
              wb_data_next = ex_addr;
            end else
`endif
            begin
              state_next     = ST_REQ;
              req_we_next    = ex_store;
              req_addr_next  = {ex_addr[DW-1:2], 2'b00};
              req_be_next    = be_calc;
              req_wdata_next = st_wdata;
              f3_next        = ex_funct3;
              lane_next      = ex_addr[1:0];
              rd_next        = ex_rd;
            end
          end else begin
            state_next   = ST_WB;
            wb_we_next   = (ex_rd != '0);
            wb_rd_next   = ex_rd;
            wb_data_next = ex_result;
          end
        end
      end
      ST_REQ: begin
        if (dmem_req_ready) begin
          if (req_we_reg) begin
            state_next = ST_WB;
            wb_we_next = 1'b0;
            wb_rd_next = rd_reg;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dmem_rsp_valid) begin
          state_next   = ST_WB;
          wb_we_next   = (rd_reg != '0);
          wb_rd_next   = rd_reg;
          wb_data_next = load_data;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      req_we_reg    <= 1'b0;
      req_addr_reg  <= '0;
      req_be_reg    <= '0;
      req_wdata_reg <= '0;
      f3_reg        <= '0;
      lane_reg      <= '0;
      rd_reg        <= '0;
      wb_we_reg     <= 1'b0;
      wb_rd_reg     <= '0;
      wb_data_reg   <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      req_we_reg    <= req_we_next;
      req_addr_reg  <= req_addr_next;
      req_be_reg    <= req_be_next;
      req_wdata_reg <= req_wdata_next;
      f3_reg        <= f3_next;
      lane_reg      <= lane_next;
      rd_reg        <= rd_next;
      wb_we_reg     <= wb_we_next;
      wb_rd_reg     <= wb_rd_next;
      wb_data_reg   <= wb_data_next;
`ifdef MISALIGN_TRAP_EN
      mis_reg       <= mis_next;
`endif
    end
  end

  assign ex_ready       = (state_reg == ST_IDLE);
  assign dmem_req_valid = (state_reg == ST_REQ);
  assign dmem_req_we    = req_we_reg;
  assign dmem_req_addr  = req_addr_reg;
  assign dmem_req_be    = req_be_reg;
  assign dmem_req_wdata = req_wdata_reg;
  assign wb_valid       = (state_reg == ST_WB);
  assign wb_we          = wb_we_reg;
  assign wb_rd          = wb_rd_reg;
  assign wb_data        = wb_data_reg;
`ifdef MISALIGN_TRAP_EN
  assign misalign       = wb_valid & mis_reg;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: vector table with a writeback scoreboard, plus hand-written back-to-back and reset sequences.
module tb_lsu_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_load;
  logic        ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [31:0] ex_result;
  logic [4:0]  ex_rd;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [3:0]  dmem_req_be;
  logic [31:0] dmem_req_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  lsu_mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_load        (ex_load),
    .ex_store       (ex_store),
    .ex_funct3      (ex_funct3),
    .ex_addr        (ex_addr),
    .ex_wdata       (ex_wdata),
    .ex_result      (ex_result),
    .ex_rd          (ex_rd),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_be    (dmem_req_be),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .wb_valid       (wb_valid),
    .wb_we          (wb_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign       (misalign)
`endif
  );

  typedef struct {
    bit          ld;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] result;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          rdy;
    int          rsp;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    bit          cbe;
    logic [31:0] ewd;
    bit          ewe;
    logic [31:0] edata;
    bit          emis;
  } vec_t;

  typedef struct {
    bit          we;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          chk_data;
    bit          mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit ld, bit st, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] result, logic [4:0] rd,
                              logic [31:0] rdata, int rdy, int rsp, logic [31:0] eaddr,
                              logic [3:0] ebe, bit cbe, logic [31:0] ewd, bit ewe,
                              logic [31:0] edata, bit emis);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.result = result;
    v.rd = rd; v.rdata = rdata; v.rdy = rdy; v.rsp = rsp; v.eaddr = eaddr; v.ebe = ebe;
    v.cbe = cbe; v.ewd = ewd; v.ewe = ewe; v.edata = edata; v.emis = emis;
    return v;
  endfunction

  // Scoreboard: every writeback beat must match the oldest pending expectation
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected actual=pulse rd=%0d data=%h required=none", wb_rd, wb_data);
      end else begin
        mon_e = sbq.pop_front();
        chk("wb_we", 32'(wb_we), 32'(mon_e.we));
        chk("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
        if (mon_e.chk_data) chk("wb_data", wb_data, mon_e.data);
`ifdef MISALIGN_TRAP_EN
        chk("misalign", 32'(misalign), 32'(mon_e.mis));
`endif
      end
    end
  end

  task automatic do_op(input int idx, input vec_t v);
    exp_t e;
    int   n;
    bit   mem;
    @(negedge clk);
    ex_valid  = 1'b1;
    ex_load   = v.ld;
    ex_store  = v.st;
    ex_funct3 = v.f3;
    ex_addr   = v.addr;
    ex_wdata  = v.wdata;
    ex_result = v.result;
    ex_rd     = v.rd;
    n = 0;
    while (!ex_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ex_ready) begin
      chk("accept_timeout", 32'(ex_ready), 32'd1);
      ex_valid = 1'b0;
      return;
    end
    $display("txn %0d ld=%0d st=%0d f3=%0d addr=%h rd=%0d", idx, v.ld, v.st, v.f3, v.addr, v.rd);
    e.we = v.ewe; e.rd = v.rd; e.data = v.edata; e.mis = v.emis;
    e.chk_data = !(v.st || v.emis);
    sbq.push_back(e);
    @(negedge clk);
    ex_valid  = 1'b0;
    ex_load   = 1'b0;
    ex_store  = 1'b0;
    ex_funct3 = 3'($urandom_range(0, 7));
    ex_addr   = $urandom;
    ex_wdata  = $urandom;
    ex_result = $urandom;
    ex_rd     = 5'($urandom_range(0, 31));
    chk("ex_ready_busy", 32'(ex_ready), 32'd0);
    mem = v.ld || v.st;
    if (!mem || v.emis) begin
      chk("wb_lat_t1", 32'(wb_valid), 32'd1);
      chk("no_req", 32'(dmem_req_valid), 32'd0);
      return;
    end
    chk("req_valid_t1", 32'(dmem_req_valid), 32'd1);
    for (int k = 0; k <= v.rdy; k++) begin
      if (k == v.rdy) begin
        dmem_req_ready = 1'b1;
        // Bogus response alongside the handshake must be ignored
        if (v.ld) begin
          dmem_rsp_valid = 1'b1;
          dmem_rsp_rdata = 32'hBAD0BAD0;
        end
      end
      chk("req_valid_hold", 32'(dmem_req_valid), 32'd1);
      chk("req_we", 32'(dmem_req_we), 32'(v.st));
      chk("req_addr", dmem_req_addr, v.eaddr);
      if (v.cbe) chk("req_be", 32'(dmem_req_be), 32'(v.ebe));
      if (v.st) chk("req_wdata", dmem_req_wdata, v.ewd);
      chk("ex_ready_stall", 32'(ex_ready), 32'd0);
      if (k < v.rdy) @(negedge clk);
    end
    @(negedge clk);
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    chk("req_drop", 32'(dmem_req_valid), 32'd0);
    if (v.st) begin
      chk("wb_after_hs", 32'(wb_valid), 32'd1);
      return;
    end
    chk("no_wb_in_wait", 32'(wb_valid), 32'd0);
    for (int k = 1; k < v.rsp; k++) begin
      @(negedge clk);
      chk("ex_ready_wait", 32'(ex_ready), 32'd0);
    end
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = v.rdata;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = $urandom;
    chk("wb_after_rsp", 32'(wb_valid), 32'd1);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'd0;
    ex_addr = '0; ex_wdata = '0; ex_result = '0; ex_rd = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;

    //          ld st f3    addr          wdata         result        rd  rdata        rdy rsp eaddr         be       cbe ewd           we edata         mis
    vecs.push_back(mk(1, 0, 3'd2, 32'h100, 32'h0, 32'h0, 5'd5, 32'hDEADBEEF, 0, 2, 32'h100, 4'b1111, 1, 32'h0, 1, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 0, 3'd0, 32'h103, 32'h0, 32'h0, 5'd6, 32'h80123456, 1, 1, 32'h100, 4'b1000, 0, 32'h0, 1, 32'hFFFFFF80, 0));
    vecs.push_back(mk(1, 0, 3'd4, 32'h103, 32'h0, 32'h0, 5'd7, 32'h80123456, 0, 3, 32'h100, 4'b1000, 0, 32'h0, 1, 32'h00000080, 0));
    vecs.push_back(mk(1, 0, 3'd1, 32'h102, 32'h0, 32'h0, 5'd8, 32'h80015555, 0, 1, 32'h100, 4'b1100, 0, 32'h0, 1, 32'hFFFF8001, 0));
    vecs.push_back(mk(1, 0, 3'd5, 32'h100, 32'h0, 32'h0, 5'd9, 32'h12349ABC, 2, 1, 32'h100, 4'b0011, 0, 32'h0, 1, 32'h00009ABC, 0));
    vecs.push_back(mk(1, 0, 3'd1, 32'h100, 32'h0, 32'h0, 5'd11, 32'hFFFF7FFF, 0, 1, 32'h100, 4'b0011, 0, 32'h0, 1, 32'h00007FFF, 0));
    vecs.push_back(mk(1, 0, 3'd0, 32'h101, 32'h0, 32'h0, 5'd10, 32'h00007F00, 0, 2, 32'h100, 4'b0010, 0, 32'h0, 1, 32'h0000007F, 0));
    vecs.push_back(mk(1, 0, 3'd4, 32'h102, 32'h0, 32'h0, 5'd0, 32'h00FF0000, 0, 1, 32'h100, 4'b0100, 0, 32'h0, 0, 32'h000000FF, 0));
    vecs.push_back(mk(0, 1, 3'd0, 32'h201, 32'h000000AB, 32'h0, 5'd0, 32'h0, 3, 0, 32'h200, 4'b0010, 1, 32'hABABABAB, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 3'd0, 32'h203, 32'h000000C3, 32'h0, 5'd4, 32'h0, 0, 0, 32'h200, 4'b1000, 1, 32'hC3C3C3C3, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 3'd1, 32'h302, 32'h0000BEEF, 32'h0, 5'd3, 32'h0, 1, 0, 32'h300, 4'b1100, 1, 32'hBEEFBEEF, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 3'd1, 32'h300, 32'h12345678, 32'h0, 5'd3, 32'h0, 0, 0, 32'h300, 4'b0011, 1, 32'h56785678, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 3'd2, 32'h404, 32'h11223344, 32'h0, 5'd2, 32'h0, 1, 0, 32'h404, 4'b1111, 1, 32'h11223344, 0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 32'h0, 32'h0, 32'h1234, 5'd0, 32'h0, 0, 0, 32'h0, 4'b0, 0, 32'h0, 0, 32'h1234, 0));
    vecs.push_back(mk(0, 0, 3'd2, 32'h0, 32'h0, 32'hCAFEF00D, 5'd31, 32'h0, 0, 0, 32'h0, 4'b0, 0, 32'h0, 1, 32'hCAFEF00D, 0));
    vecs.push_back(mk(1, 0, 3'd3, 32'h108, 32'h0, 32'h0, 5'd4, 32'h0BADF00D, 0, 1, 32'h108, 4'b1111, 1, 32'h0, 1, 32'h0BADF00D, 0));
    vecs.push_back(mk(0, 1, 3'd7, 32'h10C, 32'hA5A50001, 32'h0, 5'd1, 32'h0, 2, 0, 32'h10C, 4'b1111, 1, 32'hA5A50001, 0, 32'h0, 0));
`ifdef MISALIGN_TRAP_EN
    vecs.push_back(mk(1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 5'd5, 32'h0, 0, 1, 32'h0, 4'b0, 0, 32'h0, 0, 32'h0, 1));
    vecs.push_back(mk(0, 1, 3'd1, 32'h203, 32'h77, 32'h0, 5'd2, 32'h0, 0, 0, 32'h0, 4'b0, 0, 32'h0, 0, 32'h0, 1));
    vecs.push_back(mk(1, 0, 3'd5, 32'h101, 32'h0, 32'h0, 5'd3, 32'h0, 0, 1, 32'h0, 4'b0, 0, 32'h0, 0, 32'h0, 1));
`else
    vecs.push_back(mk(1, 0, 3'd2, 32'h106, 32'h0, 32'h0, 5'd12, 32'hA1B2C3D4, 0, 1, 32'h104, 4'b1111, 1, 32'h0, 1, 32'hA1B2C3D4, 0));
    vecs.push_back(mk(0, 1, 3'd1, 32'h203, 32'h00000077, 32'h0, 5'd2, 32'h0, 0, 0, 32'h200, 4'b1100, 1, 32'h00770077, 0, 32'h0, 0));
`endif

    repeat (3) @(negedge clk);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_req_valid", 32'(dmem_req_valid), 32'd0);
    chk("rst_req_we", 32'(dmem_req_we), 32'd0);
    chk("rst_req_addr", dmem_req_addr, 32'd0);
    chk("rst_req_be", 32'(dmem_req_be), 32'd0);
    chk("rst_req_wdata", dmem_req_wdata, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_misalign", 32'(misalign), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) do_op(i, vecs[i]);

    // Back-to-back non-memory ops with ex_valid held: accept, pulse, accept, pulse
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0; ex_result = 32'h55; ex_rd = 5'd1;
    chk("b2b_accept0", 32'(ex_ready), 32'd1);
    e.we = 1'b1; e.rd = 5'd1; e.data = 32'h55; e.chk_data = 1'b1; e.mis = 1'b0;
    sbq.push_back(e);
    $display("txn b2b0 result=%h rd=1", 32'h55);
    @(negedge clk);
    chk("b2b_pulse0", 32'(wb_valid), 32'd1);
    chk("b2b_busy", 32'(ex_ready), 32'd0);
    ex_result = 32'h66; ex_rd = 5'd0;
    @(negedge clk);
    chk("b2b_accept1", 32'(ex_ready), 32'd1);
    chk("b2b_gap", 32'(wb_valid), 32'd0);
    e.we = 1'b0; e.rd = 5'd0; e.data = 32'h66;
    sbq.push_back(e);
    $display("txn b2b1 result=%h rd=0", 32'h66);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("b2b_pulse1", 32'(wb_valid), 32'd1);

    // Reset while a load waits for its response; a late response must be dropped
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'd2; ex_addr = 32'h500; ex_rd = 5'd9;
    chk("rw_accept", 32'(ex_ready), 32'd1);
    $display("txn reset_in_wait addr=%h", 32'h500);
    @(negedge clk);
    ex_valid = 1'b0; ex_load = 1'b0;
    chk("rw_req", 32'(dmem_req_valid), 32'd1);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk("rw_in_wait", 32'(ex_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rw_rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rw_rst_req", 32'(dmem_req_valid), 32'd0);
    chk("rw_rst_wb", 32'(wb_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h13572468;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk("late_rsp_wb", 32'(wb_valid), 32'd0);
    chk("late_rsp_ready", 32'(ex_ready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("late_rsp_quiet", 32'(wb_valid), 32'd0);
    end

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
